mc_request_queue: RTL and testbench
===================================

// Module: mc_request_queue
// PURPOSE
//   Request queue at the front of the memory controller, directly downstream of the trace parser.
//   Captures packed trace entries {time,cmd,addr} on the parser's data-ready strobe and stores them in order in a FIFO.
//   Throttles the parser through data_req. Presents the head entry to the DRAM scheduler only once the CPU cycle count reaches the entry's timestamp.
// PARAMETERS
//   DEPTH        16  queue entries (power of 2, >=4)
//   ADDR_WIDTH   36  trace address width
//   MEMOP_WIDTH  2   trace command width
//   TIME_WIDTH   12  trace timestamp width
//   CYCLE_WIDTH  64  CPU cycle counter width
// PORTS
//   clock      in   1       CPU clock; all logic on posedge
//   reset_n    in   1       synchronous, active-low reset
//   cycle      in   CYCLE_WIDTH  current CPU cycle count from the parser
//   data_rdy   in   1       parser strobe: data_read is valid
//   data_read  in   TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH  {time,cmd,addr}, MSB first
//   data_req   out  1       request-next-entry to the parser
//   out_valid  out  1       head entry is due and presented
//   out_ready  in   1       scheduler accepts the head entry
//   out_cmd    out  MEMOP_WIDTH  head command (0 read, 1 write, 2 ifetch)
//   out_addr   out  ADDR_WIDTH   head address
//   out_time   out  TIME_WIDTH   head timestamp
//   count      out  $clog2(DEPTH)+1  occupancy
//   full, empty  out  1     occupancy flags
//   overflow   out  1       sticky: an entry was lost because the queue was full
//   bad_cmd    out  1       one-cycle pulse: a cmd==3 entry was dropped
// BEHAVIOUR
//   Reset (reset_n==0 at posedge): all outputs 0, except empty=1 and data_req=0.
//     Pointers, count and overflow clear. Reset mid-operation discards all stored entries.
//   Enqueue: fire on the posedge where data_rdy==1 and the previous sampled data_rdy was 0 (rising edge).
//     A multi-cycle high strobe enqueues exactly once.
//   cmd==3 on enqueue: entry is not stored; bad_cmd pulses 1 for one cycle; count is unchanged.
//   Enqueued data becomes visible at the head no earlier than the next cycle (1-cycle latency minimum).
//   out_valid = !empty && (zero-extended head time <= cycle). This is combinational from the registered head and cycle.
//   out_cmd, out_addr and out_time always show the head entry; they are 0 when empty.
//   Dequeue: fires when out_valid && out_ready at posedge; the head advances.
//     out_ready without out_valid has no effect.
//   Only the head is checked: a due entry behind a not-yet-due head waits (strict order).
//   Full with simultaneous enqueue and dequeue: both succeed; count stays DEPTH.
//   Full with enqueue and no dequeue: entry dropped; overflow set and held until reset.
//   Simultaneous enqueue and dequeue at any level: count unchanged; pointers both advance.
//   Pointers wrap modulo DEPTH. count distinguishes full from empty.
//   data_req is registered: next value = 1 iff next count <= DEPTH-2.
//     This leaves one slot of slack for the parser's in-flight entry.
//   cycle is compared as an unsigned value; timestamps are never wrapped.
// TESTING
//   1. Reset, then 3 strobes with t=5,10,10 (read, write, ifetch) while cycle=0..20 and out_ready=1
//      -> out_valid rises at cycle 5, 10, 11; entries leave in order; empty=1 at the end.
//   2. 16 strobes with out_ready=0 -> data_req drops when count reaches 15; full=1 at 16;
//      17th strobe sets overflow=1 and count stays 16.
//   3. Full queue, strobe and dequeue on the same posedge -> count=16, overflow=0;
//      new entry appears at tail order (read out last).
//   4. Entry with cmd=3 -> bad_cmd pulses 1 cycle; count unchanged; the next valid entry is queued normally.
//   5. data_rdy held high 4 cycles -> exactly one entry enqueued (count=1).
//   6. 5 entries queued, reset_n=0 for 1 cycle -> count=0, empty=1, out_valid=0, overflow=0, data_req=0;
//      data_req returns to 1 on the cycle after release.

Source files
------------

// File: rtl/mc_request_queue_if.sv
// Trace-entry path from parser to DRAM scheduler: parser strobe/data, scheduler handshake, queue status.
interface mc_request_queue_if #(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 2,
  parameter int TIME_WIDTH  = 12,
  parameter int CYCLE_WIDTH = 64
);
  localparam int ENTRY_WIDTH = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;
  localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;

  logic [CYCLE_WIDTH-1:0] cycle;
  logic                   data_rdy;
  logic [ENTRY_WIDTH-1:0] data_read;
  logic                   data_req;
  logic                   out_valid;
  logic                   out_ready;
  logic [MEMOP_WIDTH-1:0] out_cmd;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic [TIME_WIDTH-1:0]  out_time;
  logic [CNT_WIDTH-1:0]   count;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic                   bad_cmd;

  modport master (
    output cycle, data_rdy, data_read, out_ready,
    input  data_req, out_valid, out_cmd, out_addr, out_time,
    input  count, full, empty, overflow, bad_cmd
  );

  modport slave (
    input  cycle, data_rdy, data_read, out_ready,
    output data_req, out_valid, out_cmd, out_addr, out_time,
    output count, full, empty, overflow, bad_cmd
  );
endinterface

// File: rtl/mc_request_queue.sv
// Timestamp-gated in-order request FIFO between trace parser and DRAM scheduler; 1-cycle enqueue-to-head latency.
// Backpressure: data_req throttles the parser with one slot of slack; the head waits on out_ready and its timestamp.
module mc_request_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 2,
  parameter int TIME_WIDTH  = 12,
  parameter int CYCLE_WIDTH = 64
) (
  input logic clock,
  input logic reset_n,
  mc_request_queue_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  typedef struct packed {
    logic [TIME_WIDTH-1:0]  t;
    logic [MEMOP_WIDTH-1:0] cmd;
    logic [ADDR_WIDTH-1:0]  addr;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 rdy_q;
  logic                 ovf_q;
  logic                 bad_q;
  logic                 req_q;

  entry_t in_ent;
  entry_t head;
  logic   strobe;
  logic   is_bad;
  logic   is_full;
  logic   is_empty;
  logic   head_due;
  logic   deq;
  logic   push;
  logic   drop;

  assign in_ent   = entry_t'(bus.data_read);
  assign head     = mem[rd_ptr];
  assign strobe   = bus.data_rdy & ~rdy_q;
  assign is_bad   = (in_ent.cmd == MEMOP_WIDTH'(3));
  assign is_full  = (cnt == CNT_WIDTH'(DEPTH));
  assign is_empty = (cnt == '0);
  assign head_due = ({{(CYCLE_WIDTH-TIME_WIDTH){1'b0}}, head.t} <= bus.cycle);
  assign deq      = ~is_empty & head_due & bus.out_ready;
  // A full queue still accepts when the head leaves on the same edge.
  assign push     = strobe & ~is_bad & (~is_full | deq);
  assign drop     = strobe & ~is_bad & is_full & ~deq;
  assign cnt_nxt  = cnt + CNT_WIDTH'(push) - CNT_WIDTH'(deq);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b0;
      ovf_q  <= 1'b0;
      bad_q  <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      rdy_q  <= bus.data_rdy;
      bad_q  <= strobe & is_bad;
      cnt    <= cnt_nxt;
      req_q  <= (cnt_nxt <= CNT_WIDTH'(DEPTH - 2));
      if (drop) ovf_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (deq)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push) mem[wr_ptr] <= in_ent;
  end

  assign bus.out_valid = ~is_empty & head_due;
  assign bus.out_cmd   = is_empty ? '0 : head.cmd;
  assign bus.out_addr  = is_empty ? '0 : head.addr;
  assign bus.out_time  = is_empty ? '0 : head.t;
  assign bus.count     = cnt;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = ovf_q;
  assign bus.bad_cmd   = bad_q;
  assign bus.data_req  = req_q;
endmodule

// File: tb/tb_mc_request_queue.sv
// Directed scenarios plus a randomized run, all checked against a queue-based reference model.
module tb_mc_request_queue;
  localparam int DEPTH = 16;

  typedef struct {
    logic [11:0] t;
    logic [1:0]  cmd;
    logic [35:0] addr;
  } ent_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mc_request_queue_if #(.DEPTH(DEPTH)) bus ();

  mc_request_queue #(.DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit do_chk = 1'b0;
  bit cyc_inc = 1'b0;

  ent_t mq[$];
  bit   m_prev, m_ovf, m_bad, m_req;
  logic [63:0] deq_cyc[$];
  logic [35:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit vld;
    vld = (mq.size() > 0) && (64'(mq[0].t) <= bus.cycle);
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("full", 64'(bus.full), 64'(mq.size() == DEPTH));
    chk("empty", 64'(bus.empty), 64'(mq.size() == 0));
    chk("out_valid", 64'(bus.out_valid), 64'(vld));
    chk("out_cmd", 64'(bus.out_cmd), mq.size() > 0 ? 64'(mq[0].cmd) : 64'd0);
    chk("out_addr", 64'(bus.out_addr), mq.size() > 0 ? 64'(mq[0].addr) : 64'd0);
    chk("out_time", 64'(bus.out_time), mq.size() > 0 ? 64'(mq[0].t) : 64'd0);
    chk("data_req", 64'(bus.data_req), 64'(m_req));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("bad_cmd", 64'(bus.bad_cmd), 64'(m_bad));
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      deq_cyc.push_back(bus.cycle);
      if (bus.count === 1) last_addr = bus.out_addr;
    end
  endtask

  // Reference: strict-order queue, rising-edge strobe, head leaves only when due and accepted.
  task automatic model_edge();
    ent_t e;
    ent_t gone;
    bit strobe_v, deq_v, was_full;
    if (!reset_n) begin
      mq.delete();
      m_prev = 0; m_ovf = 0; m_bad = 0; m_req = 0;
    end else begin
      strobe_v = bus.data_rdy && !m_prev;
      deq_v    = (mq.size() > 0) && (64'(mq[0].t) <= bus.cycle) && bus.out_ready;
      was_full = (mq.size() == DEPTH);
      m_bad = 0;
      if (deq_v) gone = mq.pop_front();
      if (strobe_v) begin
        e.t    = bus.data_read[49:38];
        e.cmd  = bus.data_read[37:36];
        e.addr = bus.data_read[35:0];
        if (e.cmd == 2'd3) m_bad = 1;
        else if (!was_full || deq_v) mq.push_back(e);
        else m_ovf = 1;
      end
      m_req  = (mq.size() <= DEPTH - 2);
      m_prev = bus.data_rdy;
    end
  endtask

  task automatic step();
    #1;
    if (do_chk) check_all();
    model_edge();
    @(posedge clock);
    #1;
    if (cyc_inc) bus.cycle = bus.cycle + 64'd1;
  endtask

  task automatic strobe(input logic [11:0] t, input logic [1:0] c, input logic [35:0] a);
    bus.data_read = {t, c, a};
    bus.data_rdy  = 1'b1;
    step();
    bus.data_rdy  = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.data_rdy = 1'b0;
    bus.out_ready = 1'b0;
    step();
    reset_n = 1'b1;
    do_chk = 1'b1;
    cyc_inc = 1'b0;
    bus.cycle = 64'd0;
  endtask

  task automatic fill16();
    for (int i = 0; i < DEPTH; i++)
      strobe(12'($urandom_range(0, 100)), 2'($urandom_range(0, 2)), 36'({$urandom, $urandom}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cycle = 64'd0;
    bus.data_rdy = 1'b0;
    bus.data_read = '0;
    bus.out_ready = 1'b0;

    // Reset and timestamp gating
    do_reset();
    bus.out_ready = 1'b1;
    cyc_inc = 1'b1;
    deq_cyc.delete();
    strobe(12'd5, 2'd0, 36'h000000100);
    strobe(12'd10, 2'd1, 36'h000000200);
    strobe(12'd10, 2'd2, 36'h000000300);
    for (int i = 0; i < 40 && bus.cycle <= 20; i++) step();
    #1;
    chk("t1_ndeq", 64'(deq_cyc.size()), 64'd3);
    if (deq_cyc.size() == 3) begin
      chk("t1_deq0", deq_cyc[0], 64'd5);
      chk("t1_deq1", deq_cyc[1], 64'd10);
      chk("t1_deq2", deq_cyc[2], 64'd11);
    end
    chk("t1_empty", 64'(bus.empty), 64'd1);

    // Fill to full, throttle, overflow
    do_reset();
    bus.cycle = 64'hFFFF;
    for (int i = 1; i <= DEPTH; i++) begin
      strobe(12'($urandom_range(0, 4095)), 2'($urandom_range(0, 2)), 36'({$urandom, $urandom}));
      if (i == 14) chk("t2_req14", 64'(bus.data_req), 64'd1);
      if (i == 15) chk("t2_req15", 64'(bus.data_req), 64'd0);
    end
    chk("t2_full", 64'(bus.full), 64'd1);
    strobe(12'd1, 2'd0, 36'h123456789);
    chk("t2_ovf", 64'(bus.overflow), 64'd1);
    chk("t2_cnt", 64'(bus.count), 64'd16);

    // Full with simultaneous enqueue and dequeue
    do_reset();
    bus.cycle = 64'hFFFF;
    fill16();
    bus.data_read = {12'd7, 2'd1, 36'hABCDE0123};
    bus.data_rdy  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.data_rdy  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk("t3_cnt", 64'(bus.count), 64'd16);
    chk("t3_ovf", 64'(bus.overflow), 64'd0);
    bus.out_ready = 1'b1;
    last_addr = '0;
    for (int i = 0; i < 40 && bus.empty !== 1'b1; i++) step();
    step();
    chk("t3_tail", 64'(last_addr), 64'h0ABCDE0123);

    // Bad command dropped
    do_reset();
    bus.data_read = {12'd0, 2'd3, 36'h0DEAD};
    bus.data_rdy = 1'b1;
    step();
    bus.data_rdy = 1'b0;
    chk("t4_bad1", 64'(bus.bad_cmd), 64'd1);
    chk("t4_cnt0", 64'(bus.count), 64'd0);
    step();
    chk("t4_bad0", 64'(bus.bad_cmd), 64'd0);
    strobe(12'd50, 2'd1, 36'h0BEEF);
    chk("t4_cnt1", 64'(bus.count), 64'd1);

    // Held strobe enqueues once
    do_reset();
    bus.data_read = {12'd3, 2'd0, 36'h0CAFE};
    bus.data_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.data_rdy = 1'b0;
    step();
    chk("t5_cnt", 64'(bus.count), 64'd1);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) strobe(12'd100, 2'd0, 36'(i));
    reset_n = 1'b0;
    step();
    chk("t6_cnt", 64'(bus.count), 64'd0);
    chk("t6_empty", 64'(bus.empty), 64'd1);
    chk("t6_vld", 64'(bus.out_valid), 64'd0);
    chk("t6_ovf", 64'(bus.overflow), 64'd0);
    chk("t6_req0", 64'(bus.data_req), 64'd0);
    reset_n = 1'b1;
    step();
    chk("t6_req1", 64'(bus.data_req), 64'd1);

    // Randomized traffic with bursts of backpressure and occasional reset
    do_reset();
    cyc_inc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus.data_rdy  = 1'($urandom_range(0, 1));
      bus.data_read = {12'(bus.cycle) + 12'($urandom_range(0, 30)), 2'($urandom_range(0, 3)),
                       36'({$urandom, $urandom})};
      bus.out_ready = ((i % 200) < 100) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
